// File: rtl/decoder_onehot_pipe.sv
// decoder_onehot_pipe: per-lane index to one-hot decode behind a 2-entry skid-buffered valid/ready stage.
// Define DECODER_THERMO_EN to add the in_thermo port and per-beat thermometer decoding.
module decoder_onehot_pipe #(
   parameter int IDX_W     = 5,
   parameter int LANES     = 4,
   parameter int MSB_FIRST = 1,
   localparam int OUT_W    = 1 << IDX_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [LANES*IDX_W-1:0]   in_idx,
   input  logic [LANES-1:0]         in_lane_val,
   input  logic                     in_valid,
   output logic                     in_ready,
`ifdef DECODER_THERMO_EN
   input  logic                     in_thermo,
`endif
   output logic [LANES*OUT_W-1:0]   out_onehot,
   output logic                     out_valid,
   input  logic                     out_ready
);
   localparam logic [OUT_W-1:0] ONE  = OUT_W'(1);
   localparam logic [OUT_W-1:0] ONES = '1;
   logic [LANES*OUT_W-1:0] dec;
   logic [LANES*OUT_W-1:0] main_q, main_d, skid_q, skid_d;
   logic                   valid_q, valid_d, full_q, full_d, ready_q;
   logic                   acc, xfer;
   // With OUT_W = 2^IDX_W, OUT_W-1-idx is simply ~idx in IDX_W bits.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [IDX_W-1:0] idx, sh;
      logic [OUT_W-1:0] oh;
      assign idx = in_idx[k*IDX_W +: IDX_W];
      assign sh  = (MSB_FIRST != 0) ? ~idx : idx;
      assign oh  = ONE << sh;
`ifdef DECODER_THERMO_EN
      logic [OUT_W-1:0] th;
      assign th = (MSB_FIRST != 0) ? ONES << ~idx : ONES >> ~idx;
      assign dec[k*OUT_W +: OUT_W] = !in_lane_val[k] ? '0 : in_thermo ? th : oh;
`else
      assign dec[k*OUT_W +: OUT_W] = in_lane_val[k] ? oh : '0;
`endif
   end
   assign acc  = in_valid && ready_q;
   assign xfer = valid_q && out_ready;
   always_comb begin
      main_d  = main_q;
      skid_d  = skid_q;
      valid_d = valid_q;
      full_d  = full_q;
      if (full_q) begin
         if (xfer) begin
            main_d = skid_q;
            full_d = 1'b0;
         end
      end else if (acc) begin
         if (!valid_q || xfer) begin
            main_d  = dec;
            valid_d = 1'b1;
         end else begin
            skid_d = dec;
            full_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         main_q  <= main_d;
         skid_q  <= skid_d;
         valid_q <= valid_d;
         full_q  <= full_d;
         ready_q <= !full_d;
      end
   end
   assert property (@(posedge clk) disable iff (!rst_n) !(full_q && acc));
   assign in_ready   = ready_q;
   assign out_valid  = valid_q;
   assign out_onehot = main_q;
endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// tb_decoder_onehot_pipe: scoreboard bench driving MSB-first and LSB-first instances in lockstep.
module tb_decoder_onehot_pipe;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [19:0]  in_idx;
   logic [3:0]   in_lane_val;
   logic         in_valid, out_ready, in_thermo;
   logic         in_ready, out_valid, in_ready_l, out_valid_l;
   logic [127:0] out_m, out_l, held_m, em, el;
   logic [127:0] qm[$], ql[$];
   logic         stalled = 1'b0;
   int           total = 0, bad = 0;

   always #5 clk = ~clk;

   decoder_onehot_pipe #(.IDX_W(5), .LANES(4), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_lane_val(in_lane_val),
      .in_valid(in_valid), .in_ready(in_ready),
`ifdef DECODER_THERMO_EN
      .in_thermo(in_thermo),
`endif
      .out_onehot(out_m), .out_valid(out_valid), .out_ready(out_ready));

   decoder_onehot_pipe #(.IDX_W(5), .LANES(4), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_lane_val(in_lane_val),
      .in_valid(in_valid), .in_ready(in_ready_l),
`ifdef DECODER_THERMO_EN
      .in_thermo(in_thermo),
`endif
      .out_onehot(out_l), .out_valid(out_valid_l), .out_ready(out_ready));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [19:0] idx, input logic [3:0] val, input logic th,
                       input logic [127:0] xm, input logic [127:0] xl);
      int n = 0;
      in_idx = idx;
      in_lane_val = val;
      in_thermo = th;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      if (!in_ready) chk("accept_timeout", {127'b0, in_ready}, 128'd1);
      @(posedge clk);
      qm.push_back(xm);
      ql.push_back(xl);
      #1 in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("valid_pair", {127'b0, out_valid_l}, 128'd1);
         if (stalled) chk("stall_hold", out_m, held_m);
         if (out_ready) begin
            stalled = 1'b0;
            if (qm.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %h want none", out_m);
            end else begin
               em = qm.pop_front();
               el = ql.pop_front();
               chk("beat_msb", out_m, em);
               chk("beat_lsb", out_l, el);
            end
         end else begin
            stalled = 1'b1;
            held_m = out_m;
         end
      end else stalled = 1'b0;
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_idx = '0;
      in_lane_val = '0;
      in_thermo = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("rst_valid", {127'b0, out_valid}, 128'd0);
      chk("rst_data", out_m, 128'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_rst", {127'b0, in_ready}, 128'd1);
      // Basic decode, one-cycle latency, then back-to-back beats
      send({5'd31, 5'd16, 5'd1, 5'd0}, 4'b1111, 1'b0,
           {32'h00000001, 32'h00008000, 32'h40000000, 32'h80000000},
           {32'h80000000, 32'h00010000, 32'h00000002, 32'h00000001});
      chk("latency1", {127'b0, out_valid}, 128'd1);
      send({4{5'd7}}, 4'b0101, 1'b0,
           {32'h0, 32'h01000000, 32'h0, 32'h01000000},
           {32'h0, 32'h00000080, 32'h0, 32'h00000080});
      send({5'd10, 5'd5, 5'd31, 5'd0}, 4'b1111, 1'b0,
           {32'h00200000, 32'h04000000, 32'h00000001, 32'h80000000},
           {32'h00000400, 32'h00000020, 32'h80000000, 32'h00000001});
      chk("no_bubble", {127'b0, out_valid}, 128'd1);
      send({4{5'd31}}, 4'b0000, 1'b0, 128'd0, 128'd0);
      repeat (2) @(posedge clk);
      // Backpressure: A in main, B to skid, C waits upstream
      #1 send({4{5'd2}}, 4'b1111, 1'b0, {4{32'h20000000}}, {4{32'h00000004}});
      out_ready = 1'b0;
      send({4{5'd3}}, 4'b1000, 1'b0, {32'h10000000, 96'h0}, {32'h00000008, 96'h0});
      chk("skid_ready_low", {127'b0, in_ready}, 128'd0);
      fork
         send({5'd0, 5'd0, 5'd0, 5'd8}, 4'b0001, 1'b0, {96'h0, 32'h00800000}, {96'h0, 32'h00000100});
         begin
            repeat (3) @(posedge clk);
            #1 chk("ready_held_low", {127'b0, in_ready}, 128'd0);
            out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("drain_no_gap", {127'b0, out_valid}, 128'd1);
            end
         end
      join
      repeat (3) @(posedge clk);
      // Async reset with both entries full
      #1 out_ready = 1'b0;
      send({5'd31, 5'd16, 5'd1, 5'd0}, 4'b1111, 1'b0, 128'd0, 128'd0);
      send({5'd10, 5'd5, 5'd31, 5'd0}, 4'b1111, 1'b0, 128'd0, 128'd0);
      #2 rst_n = 1'b0;
      qm.delete();
      ql.delete();
      #1 chk("async_rst_valid", {127'b0, out_valid}, 128'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_async", {127'b0, in_ready}, 128'd1);
      chk("no_stale", {127'b0, out_valid}, 128'd0);
      repeat (3) @(posedge clk);
`ifdef DECODER_THERMO_EN
      #1 send({4{5'd3}}, 4'b1111, 1'b1, {4{32'hF0000000}}, {4{32'h0000000F}});
      send({4{5'd3}}, 4'b1111, 1'b0, {4{32'h10000000}}, {4{32'h00000008}});
      send({4{5'd31}}, 4'b1111, 1'b1, {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}});
      send({5'd31, 5'd31, 5'd31, 5'd0}, 4'b0011, 1'b1,
           {32'h0, 32'h0, 32'hFFFFFFFF, 32'h80000000},
           {32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000001});
`endif
      for (int i = 0; i < 20 && qm.size() != 0; i++) @(posedge clk);
      #1 chk("queue_empty", 128'(qm.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/decoder_onehot_pipe.md
Name: decoder_onehot_pipe

Overview:
- Parametrised, pipelined successor to the team's 5-to-32 one-hot decoder.
- Decodes LANES independent IDX_W-bit indices into one 2^IDX_W-bit one-hot word per lane, each gated by a per-lane valid bit.
- A valid/ready handshake with a 2-entry skid buffer registers the result. It sits between the bit-position scheduler and the bit-serial PE select lines, so backpressure never drops a decode.

Parameters:
- IDX_W, 5, index width; output word width OUT_W = 2^IDX_W. Legal range 1..8.
- LANES, 4, number of independent decode lanes. Legal range ≥1.
- MSB_FIRST, 1, 1: index 0 sets bit OUT_W-1 (legacy ordering); 0: index 0 sets bit 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_idx  in  LANES*IDX_W  lane k index at bits [k*IDX_W +: IDX_W]
- in_lane_val  in  LANES  per-lane enable; 0 forces that lane's output word to zero
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- out_onehot  out  LANES*OUT_W  lane k word at bits [k*OUT_W +: OUT_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- (THERMO_EN builds only) in_thermo  in  1  per-beat mode select, see Optional Feature

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - out_valid=0, out_onehot=0.
  - Skid entry is empty and its data is 0.
  - in_ready=1 from the first clock edge after rst_n deasserts.
- Decode is combinational on the input side, then registered:
  - For MSB_FIRST=1, lane word = (1 << (OUT_W-1-idx)) if lane_val, else 0.
  - For MSB_FIRST=0, lane word = (1 << idx) if lane_val, else 0.
  - Lanes are fully independent; any mix of lane_val is legal.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: an accepted beat appears on out_* exactly 1 cycle later when the output stage is empty or transferring.
- Throughput: 1 beat/cycle while out_ready=1.
- Storage: a main output register plus one skid register.
  - in_ready = !skid_full. It is registered and does not depend combinationally on out_ready.
- Accept while main is full and not transferring: the decoded beat goes to skid, and skid_full=1.
- Transfer with skid full: skid moves to main on the same edge, and skid_full=0.
  - If a new beat is also accepted that edge (impossible because in_ready=0), the design asserts in simulation.
- Transfer with skid empty and simultaneous accept: the new beat loads main. out_valid stays 1 with no bubble.
- Transfer with no accept: out_valid=0 next cycle. out_onehot holds its last value (don't-care for consumers).
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- out_onehot/out_valid stay stable while out_valid=1 && out_ready=0.
- rst_n asserted mid-operation:
  - Both entries clear immediately (asynchronously), and out_valid drops the same instant.
  - Any in-flight beats are discarded.
- An index with X/Z bits produces an all-X lane word in simulation only. Synthesis treats it as don't-care.

Optional Feature:
- Macro: DECODER_THERMO_EN.
- Defined:
  - Adds the in_thermo port, sampled with each accepted beat and carried with it through main/skid.
  - in_thermo=1 gives thermometer lane words: MSB_FIRST=1 sets bits OUT_W-1 down to OUT_W-1-idx; MSB_FIRST=0 sets bits 0 up to idx.
  - lane_val=0 still gives 0.
  - in_thermo=0 gives one-hot behaviour identical to the undefined build.
- Undefined: no in_thermo port; one-hot only, with no extra logic or state.

Test Plan:
- Reset/basic (IDX_W=5, LANES=4, MSB_FIRST=1):
  - Stimulus: after reset, out_ready=1; send in_idx lanes {31,16,1,0}, lane_val=4'b1111.
  - Response: next cycle out_valid=1. Lane0=0x80000000, lane1=0x40000000, lane2=0x00008000, lane3=0x00000001.
- Lane gating: lane_val=4'b0101 with idx all 7 -> lanes 0,2 = 0x01000000; lanes 1,3 = 0.
- Ordering (MSB_FIRST=0): idx=0 -> 0x00000001; idx=31 -> 0x80000000.
- Backpressure:
  - Stimulus: stream beats A,B,C back-to-back; hold out_ready=0 from the cycle A appears.
  - Response: B goes to skid and in_ready=0 next cycle; C waits upstream. Releasing out_ready gives A,B,C in order with no gaps and no loss.
- Async reset mid-stream: assert rst_n=0 between edges with both entries full -> out_valid=0 immediately; after release, in_ready=1 and no stale beat appears.
- DECODER_THERMO_EN, MSB_FIRST=1:
  - in_thermo=1, idx=3 -> 0xF0000000.
  - in_thermo=0, idx=3 -> 0x10000000.
  - idx=31 with in_thermo=1 -> 0xFFFFFFFF.
